// File: rtl/regbus_pkg.sv
// Shared types and helpers for the tristate register-bus sequencer.
// Optional feature macro: REGBUS_TURNAROUND_EN (adds a bus turnaround state).
package regbus_pkg;

  // Upper bound on trisregs addressable by the one-hot helper.
  localparam int unsigned MAX_NREG = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } regbus_state_t;

  // One-hot decode of a register index; callers truncate to their NREG.
  function automatic logic [MAX_NREG-1:0] reg_onehot(input int unsigned idx);
    reg_onehot = MAX_NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/regbus_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module regbus_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] Req,
  input  logic [GW-1:0]   ptr,
  output logic            valid,
  output logic [GW-1:0]   g
);

  logic [GW-1:0] idx;

  // Scan requesters starting from ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    g     = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = GW'((32'(ptr) + k) % NREQ);
      if (!valid && Req[idx]) begin
        valid = 1'b1;
        g     = idx;
      end
    end
  end

endmodule

// File: rtl/regbus_ctrl.sv
// Sequencer and round-robin arbiter for the shared tristate register bus.
// Each grant drives one source enable, then source enable plus destination write.
// Optional feature macro: REGBUS_TURNAROUND_EN (one all-disabled cycle after WRITE).
module regbus_ctrl
  import regbus_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned IDXW = $clog2(NREG)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*IDXW-1:0] Src,
  input  logic [NREQ*IDXW-1:0] Dst,
  output logic [NREQ-1:0]      Ack,
  output logic [NREG-1:0]      Reg_EN,
  output logic [NREG-1:0]      Reg_WE,
  output logic                 Busy
);

  localparam int unsigned GW = $clog2(NREQ);

  regbus_state_t   state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   g_q, g_d;
  logic [IDXW-1:0] src_q, src_d;
  logic [IDXW-1:0] dst_q, dst_d;
  logic [NREG-1:0] en_q, en_d;
  logic [NREG-1:0] we_q, we_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic            arb_valid;
  logic [GW-1:0]   arb_g;

  regbus_rr_arb #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_arb (
    .Req   (Req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .g     (arb_g)
  );

  // State, transfer context and registered bus controls.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      en_q    <= '0;
      we_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      en_q    <= en_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, grant capture, and outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    src_d   = src_q;
    dst_d   = dst_q;
    en_d    = '0;
    we_d    = '0;
    ack_d   = '0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          g_d     = arb_g;
          src_d   = Src[32'(arb_g)*IDXW +: IDXW];
          dst_d   = Dst[32'(arb_g)*IDXW +: IDXW];
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = WRITE;
      WRITE: begin
        ptr_d = (32'(g_q) == NREQ - 1) ? '0 : g_q + GW'(1);
`ifdef REGBUS_TURNAROUND_EN
        state_d = TURN;
`else
        state_d = IDLE;
`endif
      end
`ifdef REGBUS_TURNAROUND_EN
      TURN:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (state_d == DRIVE || state_d == WRITE) begin
      en_d = NREG'(reg_onehot(32'(src_d)));
    end
    if (state_d == WRITE) begin
      we_d       = NREG'(reg_onehot(32'(dst_d)));
      ack_d[g_d] = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  assign Reg_EN = en_q;
  assign Reg_WE = we_q;
  assign Ack    = ack_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_regbus_ctrl.sv
// Self-checking bench for regbus_ctrl with a transaction-level reference model
// and an 8 x 16-bit trisreg bank on a shared bus.
`timescale 1ns/1ps
module tb_regbus_ctrl;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int IDXW = 3;
`ifdef REGBUS_TURNAROUND_EN
  localparam int XFER_END = 3;
  localparam int GAP_EXP  = 2;
  localparam int BUSY_EXP = 3;
`else
  localparam int XFER_END = 2;
  localparam int GAP_EXP  = 1;
  localparam int BUSY_EXP = 2;
`endif

  logic                 Clock  = 1'b0;
  logic                 nReset = 1'b1;
  logic [NREQ-1:0]      Req    = '0;
  logic [NREQ*IDXW-1:0] Src    = '0;
  logic [NREQ*IDXW-1:0] Dst    = '0;
  logic [NREQ-1:0]      Ack;
  logic [NREG-1:0]      Reg_EN;
  logic [NREG-1:0]      Reg_WE;
  logic                 Busy;

  int checks = 0;
  int errors = 0;

  logic        pre_done = 1'b0;
  logic [15:0] tregs [NREG];
  logic [15:0] mregs [NREG];
  logic [15:0] bus;

  regbus_ctrl #(.NREQ(NREQ), .NREG(NREG)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Req    (Req),
    .Src    (Src),
    .Dst    (Dst),
    .Ack    (Ack),
    .Reg_EN (Reg_EN),
    .Reg_WE (Reg_WE),
    .Busy   (Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Trisreg bank: enabled source drives the bus, write-enabled register captures it.
  always_comb begin
    bus = '0;
    for (int k = 0; k < NREG; k++) if (Reg_EN[k]) bus = bus | tregs[k];
  end

  always @(posedge Clock) begin
    if (!pre_done) begin
      for (int k = 0; k < NREG; k++) tregs[k] <= 16'h1000 + 16'(k);
    end else begin
      for (int k = 0; k < NREG; k++) if (Reg_WE[k]) tregs[k] <= bus;
    end
  end

  // Reference model: a transfer is a timeline t=0 (source on), t=1 (write+ack),
  // optionally t=2 (bus quiet); a new grant is only taken while idle.
  int          m_t   = -1;
  int          m_g   = 0;
  int          m_src = 0;
  int          m_dst = 0;
  int          m_ptr = 0;
  logic [7:0]  e_en  = '0;
  logic [7:0]  e_we  = '0;
  logic [3:0]  e_ack = '0;
  logic        e_busy = 1'b0;

  always @(posedge Clock or negedge nReset) begin
    if (!pre_done) for (int k = 0; k < NREG; k++) mregs[k] = 16'h1000 + 16'(k);
    if (!nReset) begin
      m_t   = -1;
      m_ptr = 0;
    end else if (m_t >= 0) begin
      if (m_t == 1) begin
        mregs[m_dst] = mregs[m_src];
        m_ptr        = (m_g + 1) % NREQ;
      end
      m_t++;
      if (m_t == XFER_END) m_t = -1;
    end else if (Req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_t < 0 && Req[2'((m_ptr + k) % NREQ)]) begin
          m_g = (m_ptr + k) % NREQ;
          m_t = 0;
        end
      end
      m_src = int'(Src[m_g*IDXW +: IDXW]);
      m_dst = int'(Dst[m_g*IDXW +: IDXW]);
    end
    e_en  = '0;
    e_we  = '0;
    e_ack = '0;
    if (m_t == 0 || m_t == 1) e_en[3'(m_src)] = 1'b1;
    if (m_t == 1) begin
      e_we[3'(m_dst)] = 1'b1;
      e_ack[2'(m_g)]  = 1'b1;
    end
    e_busy = (m_t >= 0);
  end

  // Per-cycle compare of every DUT output and the register bank.
  always @(negedge Clock) begin
    if (pre_done) begin
      chk("reg_en", 32'(Reg_EN), 32'(e_en));
      chk("reg_we", 32'(Reg_WE), 32'(e_we));
      chk("ack", 32'(Ack), 32'(e_ack));
      chk("busy", 32'(Busy), 32'(e_busy));
      chk("en_onehot0", 32'($onehot0(Reg_EN)), 32'd1);
      chk("we_onehot0", 32'($onehot0(Reg_WE)), 32'd1);
      chk("ack_onehot0", 32'($onehot0(Ack)), 32'd1);
      for (int k = 0; k < NREG; k++) chk($sformatf("reg%0d", k), 32'(tregs[k]), 32'(mregs[k]));
    end
  end

  logic [7:0] eh [$];
  logic [7:0] wh [$];
  logic [3:0] ah [$];
  logic       bh [$];
  int         acks [$];

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    Req    = '0;
    tick();
    tick();
    nReset = 1'b1;
    tick();
  endtask

  // Record outputs each cycle; after n acks drop all Req, record `extra` more cycles.
  task automatic collect(input int n, input int budget, input int extra);
    int left;
    left = -1;
    eh.delete(); wh.delete(); ah.delete(); bh.delete(); acks.delete();
    for (int j = 0; j < budget; j++) begin
      @(negedge Clock);
      eh.push_back(Reg_EN);
      wh.push_back(Reg_WE);
      ah.push_back(Ack);
      bh.push_back(Busy);
      for (int i = 0; i < NREQ; i++) if (Ack[i]) acks.push_back(i);
      @(posedge Clock);
      #2;
      if (left >= 0) begin
        if (left == 0) break;
        left--;
      end else if (acks.size() >= n) begin
        Req  = '0;
        left = extra;
      end
    end
    chk("ack_count", 32'(acks.size()), 32'(n));
  endtask

  function automatic int ack_at(input int k);
    return (k < acks.size()) ? acks[k] : 99;
  endfunction

  logic [3:0]  a;
  logic [15:0] saved;
  int          nb, found, st, en1, st2;
  int          rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    #1 nReset = 1'b0;
    @(posedge Clock);
    #1 pre_done = 1'b1;
    #1;
    chk("rst_en", 32'(Reg_EN), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);

    // Single transfer reg2 -> reg5 by requester 0.
    do_reset();
    Req[0] = 1'b1; Src[2:0] = 3'd2; Dst[2:0] = 3'd5;
    collect(1, 12, 3);
    chk("t1_en_c0", 32'(eh[0]), 32'h00);
    chk("t1_en_c1", 32'(eh[1]), 32'h04);
    chk("t1_we_c1", 32'(wh[1]), 32'h00);
    chk("t1_ack_c1", 32'(ah[1]), 32'h0);
    chk("t1_en_c2", 32'(eh[2]), 32'h04);
    chk("t1_we_c2", 32'(wh[2]), 32'h20);
    chk("t1_ack_c2", 32'(ah[2]), 32'h1);
    chk("t1_en_c3", 32'(eh[3]), 32'h00);
    nb = 0;
    foreach (bh[j]) if (bh[j]) nb++;
    chk("t1_busy_cycles", 32'(nb), 32'(BUSY_EXP));
    chk("t1_reg5", 32'(tregs[5]), 32'h1002);

    // Round-robin with all requesters held high.
    do_reset();
    Src = {3'd3, 3'd2, 3'd1, 3'd0};
    Dst = {3'd7, 3'd6, 3'd5, 3'd4};
    Req = 4'hF;
    collect(5, 60, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), 32'(ack_at(k)), 32'(rr_exp[k]));

    // Pointer resume: grant to 1 leaves ptr=2, so 0 wins over 1.
    do_reset();
    Src[5:3] = 3'd1; Dst[5:3] = 3'd6;
    Req = 4'b0010;
    collect(1, 20, 0);
    chk("ptr_first", 32'(ack_at(0)), 32'd1);
    Src[2:0] = 3'd0; Dst[2:0] = 3'd7;
    Req = 4'b0011;
    collect(1, 20, 0);
    chk("ptr_resume", 32'(ack_at(0)), 32'd0);

    // Source equals destination.
    do_reset();
    Src[8:6] = 3'd3; Dst[8:6] = 3'd3;
    Req = 4'b0100;
    collect(1, 20, 0);
    found = 0;
    foreach (eh[j]) if (eh[j] == 8'h08 && wh[j] == 8'h08 && ah[j] == 4'b0100) found++;
    chk("self_xfer_cycle", 32'(found), 32'd1);
    chk("self_reg3", 32'(tregs[3]), 32'h1003);

    // Reset during DRIVE abandons the transfer.
    Src[5:3] = 3'd0; Dst[5:3] = 3'd6;
    saved = tregs[6];
    Req = 4'b0010;
    found = 0;
    for (int j = 0; j < 10 && found == 0; j++) begin
      @(negedge Clock);
      if (Busy && Reg_WE == '0 && Reg_EN != '0) found = 1;
    end
    chk("rst_mid_drive_seen", 32'(found), 32'd1);
    #1 nReset = 1'b0;
    #1;
    chk("rst_mid_en", 32'(Reg_EN), 32'h0);
    chk("rst_mid_we", 32'(Reg_WE), 32'h0);
    chk("rst_mid_ack", 32'(Ack), 32'h0);
    chk("rst_mid_busy", 32'(Busy), 32'h0);
    nb = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clock);
      if (Ack != '0) nb++;
    end
    chk("rst_mid_no_ack", 32'(nb), 32'd0);
    chk("rst_mid_reg6", 32'(tregs[6]), 32'(saved));
    @(posedge Clock);
    #2 nReset = 1'b1;
    Src[2:0] = 3'd1; Dst[2:0] = 3'd7;
    Req = 4'b0011;
    collect(1, 20, 0);
    chk("rst_mid_first_grant", 32'(ack_at(0)), 32'd0);

    // Back-to-back transfers from requester 2: count quiet bus cycles between.
    do_reset();
    Src[8:6] = 3'd1; Dst[8:6] = 3'd2;
    Req = 4'b0100;
    collect(2, 30, 0);
    st = -1; en1 = -1; st2 = -1;
    foreach (eh[j]) begin
      if (eh[j] != '0) begin
        if (st < 0) st = j;
        else if (en1 >= 0 && st2 < 0) st2 = j;
      end else if (st >= 0 && en1 < 0) begin
        en1 = j;
      end
    end
    chk("turn_gap", 32'(st2 - en1), 32'(GAP_EXP));

    // Randomized requesters following the Req/Ack protocol, with occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Clock);
      a = Ack;
      @(posedge Clock);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (a[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            Src[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
            Dst[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
          end else begin
            Req[i] = 1'b0;
          end
        end else if (!Req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            Req[i] = 1'b1;
            Src[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
            Dst[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          Src[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
          Dst[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
        end
      end
      if (cyc % 700 == 350) nReset = 1'b0;
      if (cyc % 700 == 352) nReset = 1'b1;
    end
    Req = '0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
